// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: word loads/stores over a req/ack data bus,
// pipeline stall generation, bus timeout detection and the MEM/WB register.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_reg_wr,
   input  logic        mem_mem_wr,
   input  logic        mem_mem_rd,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_wdata,
   input  logic [4:0]  mem_waddr,
   output logic        stall_req,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        wb_reg_wr,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        addr_err,
   output logic        bus_err
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] rdata_q, rdata_nxt;
   logic              tmo, tmo_nxt;
   logic              stall_c;

   logic              req_nxt, we_nxt;
   logic [DATA_W-1:0] addr_nxt, wdata_nxt;
   logic              wb_reg_wr_nxt;
   logic [REG_W-1:0]  wb_waddr_nxt;
   logic [DATA_W-1:0] wb_wdata_nxt;
   logic              addr_err_nxt, bus_err_nxt;

   logic access, is_store, is_load, misaligned;

   // A store wins when both read and write are flagged.
   assign access     = mem_mem_rd | mem_mem_wr;
   assign is_store   = mem_mem_wr;
   assign is_load    = mem_mem_rd & ~mem_mem_wr;
   assign misaligned = (mem_alu_result[1:0] != 2'b00);

   assign stall_req = stall_c & ~rst;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rdata_nxt     = rdata_q;
      tmo_nxt       = tmo;
      req_nxt       = dbus_req;
      we_nxt        = dbus_we;
      addr_nxt      = dbus_addr;
      wdata_nxt     = dbus_wdata;
      wb_reg_wr_nxt = wb_reg_wr;
      wb_waddr_nxt  = wb_waddr;
      wb_wdata_nxt  = wb_wdata;
      addr_err_nxt  = 1'b0;
      bus_err_nxt   = 1'b0;
      stall_c       = 1'b0;

      case (state)
         IDLE: begin
            if (!access) begin
               wb_reg_wr_nxt = mem_reg_wr;
               wb_waddr_nxt  = mem_waddr;
               wb_wdata_nxt  = mem_alu_result;
            end else if (misaligned) begin
               wb_reg_wr_nxt = 1'b0;
               addr_err_nxt  = 1'b1;
            end else begin
               stall_c       = 1'b1;
               req_nxt       = 1'b1;
               we_nxt        = is_store;
               addr_nxt      = mem_alu_result;
               wdata_nxt     = mem_wdata;
               cnt_nxt       = '0;
               tmo_nxt       = 1'b0;
               wb_reg_wr_nxt = 1'b0;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            stall_c       = 1'b1;
            wb_reg_wr_nxt = 1'b0;
            // An ack in the last permitted cycle still counts as success.
            if (dbus_ack) begin
               req_nxt   = 1'b0;
               rdata_nxt = dbus_rdata;
               state_nxt = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               req_nxt   = 1'b0;
               tmo_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            wb_waddr_nxt = mem_waddr;
            state_nxt    = IDLE;
            if (tmo) begin
               wb_reg_wr_nxt = 1'b0;
               bus_err_nxt   = 1'b1;
            end else begin
               wb_reg_wr_nxt = mem_reg_wr;
               wb_wdata_nxt  = is_load ? rdata_q : mem_alu_result;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers; reset abandons any outstanding transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         rdata_q    <= '0;
         tmo        <= 1'b0;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         wb_reg_wr  <= 1'b0;
         wb_waddr   <= '0;
         wb_wdata   <= '0;
         addr_err   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         rdata_q    <= rdata_nxt;
         tmo        <= tmo_nxt;
         dbus_req   <= req_nxt;
         dbus_we    <= we_nxt;
         dbus_addr  <= addr_nxt;
         dbus_wdata <= wdata_nxt;
         wb_reg_wr  <= wb_reg_wr_nxt;
         wb_waddr   <= wb_waddr_nxt;
         wb_wdata   <= wb_wdata_nxt;
         addr_err   <= addr_err_nxt;
         bus_err    <= bus_err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and random instructions with a
// scoreboard of expected write-back results and a configurable-latency bus responder.
module tb_mem_stage;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_reg_wr, mem_mem_wr, mem_mem_rd;
   logic [31:0] mem_alu_result, mem_wdata;
   logic [4:0]  mem_waddr;
   logic        stall_req, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        wb_reg_wr;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        addr_err, bus_err;

   int n_checks = 0;
   int n_errors = 0;

   int   resp_ack_at = 0;
   int   busy_cnt = 0;
   logic resp_ack = 1'b0;
   logic stray_ack = 1'b0;

   typedef struct {
      logic        reg_wr;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        aerr;
      logic        berr;
      int          stalls;
      int          reqs;
   } exp_t;

   exp_t sb[$];

   mem_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .mem_reg_wr(mem_reg_wr), .mem_mem_wr(mem_mem_wr), .mem_mem_rd(mem_mem_rd),
      .mem_alu_result(mem_alu_result), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
      .stall_req(stall_req), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
      .wb_reg_wr(wb_reg_wr), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .addr_err(addr_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   assign dbus_ack = resp_ack | stray_ack;

   // Bus responder: acks in the resp_ack_at-th BUSY cycle (0 = never).
   always @(negedge clk) begin
      if (dbus_req) begin
         busy_cnt = busy_cnt + 1;
         resp_ack = (resp_ack_at != 0) && (busy_cnt == resp_ack_at);
      end else begin
         busy_cnt = 0;
         resp_ack = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic mw, input logic mr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa);
      mem_reg_wr     = rw;
      mem_mem_wr     = mw;
      mem_mem_rd     = mr;
      mem_alu_result = addr;
      mem_wdata      = wd;
      mem_waddr      = wa;
   endtask

   // Issue one instruction, follow it to retirement and score the result.
   task automatic run_instr(input logic rw, input logic mw, input logic mr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] wa, input int ack_at, input logic [31:0] rd);
      exp_t e;
      exp_t got;
      int   stalls = 0;
      int   reqs = 0;
      int   iter = 0;
      bit   done = 0;

      e.reg_wr = 1'b0; e.waddr = wa; e.wdata = 32'h0;
      e.aerr = 1'b0; e.berr = 1'b0; e.stalls = 0; e.reqs = 0;
      if (!(mr | mw)) begin
         e.reg_wr = rw;
         e.wdata  = addr;
      end else if (addr[1:0] != 2'b00) begin
         e.aerr = 1'b1;
      end else if (ack_at >= 1 && ack_at <= int'(TMO)) begin
         e.reg_wr = rw;
         e.wdata  = (mr && !mw) ? rd : addr;
         e.stalls = 1 + ack_at;
         e.reqs   = ack_at;
      end else begin
         e.berr   = 1'b1;
         e.stalls = 1 + int'(TMO);
         e.reqs   = int'(TMO);
      end
      sb.push_back(e);

      resp_ack_at = ack_at;
      dbus_rdata  = rd;
      drive(rw, mw, mr, addr, wd, wa);

      while (!done && iter < 64) begin
         #1;
         if (stall_req) stalls++;
         if (dbus_req) begin
            reqs++;
            check("dbus_addr", dbus_addr, addr);
            check("dbus_we", 32'(dbus_we), 32'(mw));
            check("dbus_wdata", dbus_wdata, wd);
         end
         if (iter > 0) begin
            check("bubble_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
            check("bubble_bus_err", 32'(bus_err), 32'h0);
         end
         if (!stall_req) done = 1;
         @(negedge clk);
         iter++;
      end

      if (!done) begin
         check("retire_timeout", 32'h0, 32'h1);
         void'(sb.pop_front());
      end else begin
         #1;
         got = sb.pop_front();
         check("wb_reg_wr", 32'(wb_reg_wr), 32'(got.reg_wr));
         if (got.reg_wr) begin
            check("wb_waddr", 32'(wb_waddr), 32'(got.waddr));
            check("wb_wdata", wb_wdata, got.wdata);
         end
         check("addr_err", 32'(addr_err), 32'(got.aerr));
         check("bus_err", 32'(bus_err), 32'(got.berr));
         check("stall_cycles", 32'(stalls), 32'(got.stalls));
         check("req_cycles", 32'(reqs), 32'(got.reqs));
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_stall_req"}, 32'(stall_req), 32'h0);
      check({pfx, "_dbus_req"}, 32'(dbus_req), 32'h0);
      check({pfx, "_dbus_we"}, 32'(dbus_we), 32'h0);
      check({pfx, "_dbus_addr"}, dbus_addr, 32'h0);
      check({pfx, "_dbus_wdata"}, dbus_wdata, 32'h0);
      check({pfx, "_wb_reg_wr"}, 32'(wb_reg_wr), 32'h0);
      check({pfx, "_wb_waddr"}, 32'(wb_waddr), 32'h0);
      check({pfx, "_wb_wdata"}, wb_wdata, 32'h0);
      check({pfx, "_addr_err"}, 32'(addr_err), 32'h0);
      check({pfx, "_bus_err"}, 32'(bus_err), 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      int          kind;

      rst = 1'b1;
      dbus_rdata = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      run_instr(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0);
      run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd8, 1, 32'hDEAD_BEEF);
      run_instr(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 5'd0, 4, 32'h0);
      run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h1111_1111);
      run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd10, 0, 32'h0);
      stray_ack = 1'b1;
      run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd3, 0, 32'h0);
      stray_ack = 1'b0;
      run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 5'd11, 4, 32'hCAFE_F00D);
      run_instr(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 0, 32'h0);
      run_instr(1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h55AA_55AA, 5'd12, 2, 32'h9999_9999);

      for (int i = 0; i < 24; i++) begin
         a = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         kind = $urandom_range(0, 3);
         run_instr(1'($urandom_range(0, 1)), kind[1], kind[0], a, $urandom(),
                   5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom());
      end

      // Reset in the second BUSY cycle of a load that never gets acked.
      resp_ack_at = 0;
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("stall_in_reset", 32'(stall_req), 32'h0);
      @(negedge clk);
      #1;
      check_all_zero("midbusy_reset");
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      #1;
      check("post_reset_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
      check("post_reset_dbus_req", 32'(dbus_req), 32'h0);
      check("post_reset_bus_err", 32'(bus_err), 32'h0);
      run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd13, 2, 32'h0BAD_CAFE);
      run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS32 pipeline, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs, performs word loads/stores over a variable-latency request/acknowledge data bus, and stalls the front of the pipeline while an access is outstanding. It also contains the MEM/WB register, so its `wb_*` outputs drive the register-file write port directly.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles waiting for `dbus_ack`, legal range 1..255.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_reg_wr` in 1: instruction writes a register.
- `mem_mem_wr` in 1: instruction is a store (`sw`).
- `mem_mem_rd` in 1: instruction is a load (`lw`).
- `mem_alu_result` in 32: ALU result; this is the effective address for loads/stores.
- `mem_wdata` in 32: store data (rt value).
- `mem_waddr` in 5: destination register.
- `stall_req` out 1: combinational; hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `dbus_req` out 1: registered bus request.
- `dbus_we` out 1: registered; 1 = write.
- `dbus_addr` out 32: registered word address (byte address, bits[1:0]=0).
- `dbus_wdata` out 32: registered write data.
- `dbus_ack` in 1: single-cycle completion strobe from memory.
- `dbus_rdata` in 32: read data, valid in the `dbus_ack` cycle.
- `wb_reg_wr` out 1: registered register-file write enable.
- `wb_waddr` out 5: registered write address.
- `wb_wdata` out 32: registered write data.
- `addr_err` out 1: registered one-cycle pulse for a misaligned access.
- `bus_err` out 1: registered one-cycle pulse for a bus timeout.

## Operation
- Access definition: an access is `mem_mem_rd | mem_mem_wr`. If both are set, the instruction is treated as a store.
- Misaligned access: `mem_alu_result[1:0] != 0`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE, no access:** `stall_req`=0. Next edge: `wb_reg_wr`<=`mem_reg_wr`, `wb_waddr`<=`mem_waddr`, `wb_wdata`<=`mem_alu_result`.
- **IDLE, misaligned access:** no bus activity and `stall_req`=0. Next edge: `wb_reg_wr`<=0 and `addr_err`<=1.
- **IDLE, aligned access:** `stall_req`=1. Next edge:
  - `dbus_req`<=1, `dbus_we`<=store, `dbus_addr`<=`mem_alu_result`, `dbus_wdata`<=`mem_wdata`.
  - Counter<=0, `wb_reg_wr`<=0, state<=BUSY.
- **BUSY:** `stall_req`=1; `dbus_*` outputs held; `wb_reg_wr`<=0 each edge.
  - `dbus_ack`=1: `dbus_req`<=0, read-data latch<=`dbus_rdata`, state<=DONE.
  - No ack and counter==TIMEOUT-1: `dbus_req`<=0, timeout flag set, state<=DONE.
  - Otherwise: counter<=counter+1.
  - Ack in the final permitted cycle counts as success; timeout is not taken.
- **DONE:** `stall_req`=0; EX/MEM inputs still hold the same instruction. Next edge: `wb_waddr`<=`mem_waddr`, state<=IDLE, and:
  - Success: `wb_reg_wr`<=`mem_reg_wr`; `wb_wdata`<=(load ? latched rdata : `mem_alu_result`).
  - Timeout: `wb_reg_wr`<=0 and `bus_err`<=1.
- `addr_err` and `bus_err` are cleared on every edge where they are not being set.
- Register 0 is passed through unchanged; the register file ignores writes to r0.
- `dbus_ack` is ignored in IDLE and DONE. This covers stray or late acks after a timeout.
- Upstream inputs are guaranteed stable while `stall_req`=1 or the state is DONE.

## Timing
- Non-memory instruction: result at the `wb_*` outputs 1 edge after entering MEM; zero stalls.
- Aligned access with ack in the first BUSY cycle: IDLE → BUSY → DONE, result after 3 edges.
  - This minimum costs 2 stall cycles, in IDLE and BUSY; each extra ack-wait cycle adds 1 stall.
- Worst case (timeout): 1 + TIMEOUT stall cycles, then DONE.
- `wb_reg_wr`=0 bubbles are issued on every stalled edge.
- `stall_req` is forced to 0 while `rst`=1.
- Reset (any state, including mid-BUSY):
  - State<=IDLE; counter and read-data latch<=0.
  - `dbus_req`/`dbus_we`<=0; `dbus_addr`/`dbus_wdata`<=0.
  - `wb_reg_wr`<=0, `wb_waddr`<=0, `wb_wdata`<=0; `addr_err`/`bus_err`<=0.
  - The outstanding bus transaction is abandoned.

## Test plan
- **ALU pass-through:** `mem_reg_wr`=1, `mem_waddr`=5, `mem_alu_result`=0x1234_5678, no access → next edge `wb_reg_wr`=1, `wb_waddr`=5, `wb_wdata`=0x1234_5678; `stall_req` never 1.
- **Load with 0-wait ack:** `lw`, address 0x100, `mem_waddr`=8, ack with rdata=0xDEAD_BEEF in the first BUSY cycle.
  - `stall_req`=1 for exactly 2 cycles; `dbus_addr`=0x100 and `dbus_we`=0.
  - Edge 3: `wb_reg_wr`=1, `wb_waddr`=8, `wb_wdata`=0xDEAD_BEEF.
- **Store with 3-cycle ack wait:** `sw`, address 0x20, `mem_wdata`=0xA5A5_A5A5 → `dbus_we`=1 and `dbus_wdata`=0xA5A5_A5A5 held for 4 BUSY cycles; `stall_req`=1 for 5 cycles; `wb_reg_wr`=0 throughout.
- **Misaligned load:** address 0x102 → `dbus_req` stays 0, `stall_req`=0; next edge `addr_err`=1 for one cycle and `wb_reg_wr`=0.
- **Timeout, TIMEOUT=4, no ack:**
  - `dbus_req` high for exactly 4 cycles; `bus_err`=1 pulse after DONE; `wb_reg_wr`=0.
  - A stray ack injected 2 cycles later is ignored.
  - Repeat with the ack in the 4th BUSY cycle → success, no `bus_err`.
- **Reset mid-BUSY:** assert `rst` on the 2nd BUSY cycle → next edge all outputs 0 and state IDLE; a subsequent ack has no effect; the following `lw` completes normally.
